// File: rtl/uart_types.sv
// Shared UART types: baud divisor widths and default oversampling and reset divisor.
package uart_types;

    localparam int BAUD_DIV_W     = 16;
    localparam int BAUD_FRAC_W    = 4;
    localparam int BAUD_OSR       = 16;
    localparam int BAUD_RESET_DIV = 4;

    typedef logic [BAUD_DIV_W-1:0]  baud_div_t;
    typedef logic [BAUD_FRAC_W-1:0] baud_frac_t;

endpackage

// File: rtl/uart_frac_divider.sv
// Fractional clock divider producing the raw oversampling tick and divisor-change ack.
// tick_stb is the pre-register reload strobe; os_tick and div_ack follow it by one cycle.
module uart_frac_divider
    import uart_types::*;
#(
    parameter int DIV_W     = BAUD_DIV_W,
    parameter int FRAC_W    = BAUD_FRAC_W,
    parameter int RESET_DIV = BAUD_RESET_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              div_ack,
    output logic              tick_stb,
    output logic              os_tick
);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [DIV_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W-1:0]  pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic              pend_vld_q, pend_vld_d;
    logic              ack_q, ack_d;
    logic              os_q, os_d;

    logic              reload;
    logic              apply;
    logic              carry;
    logic [DIV_W-1:0]  use_int;
    logic [DIV_W-1:0]  eff_int;
    logic [FRAC_W-1:0] use_frac;
    logic [FRAC_W-1:0] acc_base;
    logic [FRAC_W-1:0] acc_sum;

    always_comb begin
        reload   = enable && (cnt_q == '0);
        // A pending divisor lands on the next reload, or immediately while frozen.
        apply    = pend_vld_q && (reload || !enable);
        use_int  = apply ? pend_int_q  : act_int_q;
        use_frac = apply ? pend_frac_q : act_frac_q;
        eff_int  = (use_int == '0) ? DIV_W'(1) : use_int;
        acc_base = apply ? '0 : acc_q;
        {carry, acc_sum} = {1'b0, acc_base} + {1'b0, use_frac};

        cnt_d       = cnt_q;
        acc_d       = acc_q;
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        pend_vld_d  = pend_vld_q;
        ack_d       = apply;
        os_d        = reload;

        if (apply) begin
            act_int_d  = pend_int_q;
            act_frac_d = pend_frac_q;
            acc_d      = '0;
            pend_vld_d = 1'b0;
        end

        if (reload) begin
            acc_d = acc_sum;
            cnt_d = eff_int - DIV_W'(1) + DIV_W'(carry);
        end else if (enable) begin
            cnt_d = cnt_q - DIV_W'(1);
        end

        // A load arriving alongside an application becomes the next pending value.
        if (div_load) begin
            pend_int_d  = div_int;
            pend_frac_d = div_frac;
            pend_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= DIV_W'(RESET_DIV - 1);
            acc_q       <= '0;
            act_int_q   <= DIV_W'(RESET_DIV);
            act_frac_q  <= '0;
            pend_int_q  <= '0;
            pend_frac_q <= '0;
            pend_vld_q  <= 1'b0;
            ack_q       <= 1'b0;
            os_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            pend_vld_q  <= pend_vld_d;
            ack_q       <= ack_d;
            os_q        <= os_d;
        end
    end

    assign tick_stb = reload;
    assign os_tick  = os_q;
    assign div_ack  = ack_q;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: fractional oversampling tick plus TX bit and re-phasable RX mid-bit ticks.
// All outputs registered; ticks appear one cycle after the divider reload decision.
module uart_baud_gen
    import uart_types::*;
#(
    parameter int DIV_W     = BAUD_DIV_W,
    parameter int FRAC_W    = BAUD_FRAC_W,
    parameter int OSR       = BAUD_OSR,
    parameter int RESET_DIV = BAUD_RESET_DIV
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [DIV_W-1:0]       div_int,
    input  logic [FRAC_W-1:0]      div_frac,
    input  logic                   div_load,
    output logic                   div_ack,
    input  logic                   rx_resync,
    output logic                   os_tick,
    output logic                   tx_bit_tick,
    output logic                   rx_sample_tick,
    output logic [$clog2(OSR)-1:0] rx_phase
);

    localparam int              PH_W    = $clog2(OSR);
    localparam logic [PH_W-1:0] TX_LAST = PH_W'(OSR - 1);
    localparam logic [PH_W-1:0] RX_MID  = PH_W'(OSR / 2 - 1);

    logic            tick_stb;
    logic [PH_W-1:0] tx_ph_q, tx_ph_d;
    logic [PH_W-1:0] rx_ph_q, rx_ph_d;
    logic            tx_bit_q, tx_bit_d;
    logic            rx_smp_q, rx_smp_d;

    uart_frac_divider #(
        .DIV_W     (DIV_W),
        .FRAC_W    (FRAC_W),
        .RESET_DIV (RESET_DIV)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
        .div_ack  (div_ack),
        .tick_stb (tick_stb),
        .os_tick  (os_tick)
    );

    // Phases advance on the edge that launches os_tick; OSR is a power of two so they wrap naturally.
    always_comb begin
        tx_ph_d  = tx_ph_q;
        rx_ph_d  = rx_ph_q;
        tx_bit_d = 1'b0;
        rx_smp_d = 1'b0;
        if (tick_stb) begin
            tx_ph_d  = tx_ph_q + PH_W'(1);
            tx_bit_d = (tx_ph_q == TX_LAST);
            rx_ph_d  = rx_ph_q + PH_W'(1);
            rx_smp_d = (rx_ph_q == RX_MID);
        end
        // Resync sampled on the tick-launching edge wins and swallows that sample.
        if (rx_resync) begin
            rx_ph_d  = '0;
            rx_smp_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ph_q  <= '0;
            rx_ph_q  <= '0;
            tx_bit_q <= 1'b0;
            rx_smp_q <= 1'b0;
        end else begin
            tx_ph_q  <= tx_ph_d;
            rx_ph_q  <= rx_ph_d;
            tx_bit_q <= tx_bit_d;
            rx_smp_q <= rx_smp_d;
        end
    end

    assign tx_bit_tick    = tx_bit_q;
    assign rx_sample_tick = rx_smp_q;
    assign rx_phase       = rx_ph_q;

endmodule
